// File: rtl/kv32_top.sv
// kv32_top: multi-cycle RV32I core (FETCH/EXEC/MEM/HALT) with separate
// synchronous-read instruction and data memories.

module kv32_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rdata_q;

  // Byte-enabled write and one-cycle registered read; contents are never reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) begin
        mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module kv32_top #(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  output logic halt
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        halt_q, halt_d;
  logic [31:0] rf_q [0:31];
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_off_q, ld_off_d;

  logic [31:0] instr, dmem_rdata;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, alu_b, alu_res, mem_addr, pc_plus4;
  logic [31:0] wb_val, next_pc, st_data, ld_shift, load_val, rf_wd;
  logic [3:0]  st_be;
  logic        illegal, is_sys, is_load, wb_en, jump, st_en, misalign, halt_cond;
  logic        rf_we, dmem_we;
  logic [4:0]  rf_wa;
  logic        unused_addr;

  kv32_mem #(.DEPTH(IMEM_DEPTH)) i_imem (
    .clk_i   (clk),
    .addr_i  (pc_q[IAW+1:2]),
    .we_i    (1'b0),
    .be_i    (4'b0000),
    .wdata_i (32'h0000_0000),
    .rdata_o (instr)
  );

  kv32_mem #(.DEPTH(DMEM_DEPTH)) i_dmem (
    .clk_i   (clk),
    .addr_i  (mem_addr[DAW+1:2]),
    .we_i    (dmem_we),
    .be_i    (st_be),
    .wdata_i (st_data),
    .rdata_o (dmem_rdata)
  );

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'h000};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rs1_v    = (rs1 == 5'd0) ? 32'h0000_0000 : rf_q[rs1];
  assign rs2_v    = (rs2 == 5'd0) ? 32'h0000_0000 : rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;
  assign mem_addr = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign alu_b    = (opcode == OP_REG) ? rs2_v : imm_i;
  assign shamt    = alu_b[4:0];
  assign halt_cond   = illegal | is_sys | misalign | (jump & next_pc[1]);
  assign unused_addr = ^mem_addr[31:DAW+2];
  assign halt        = halt_q;

  // Integer ALU shared by OP and OP-IMM; subtract only exists in the register form.
  always_comb begin
    alu_res = 32'h0000_0000;
    case (funct3)
      3'b000: begin
        if ((opcode == OP_REG) && instr[30]) alu_res = rs1_v - alu_b;
        else                                 alu_res = rs1_v + alu_b;
      end
      3'b001: alu_res = rs1_v << shamt;
      3'b010: alu_res = {31'd0, $signed(rs1_v) < $signed(alu_b)};
      3'b011: alu_res = {31'd0, rs1_v < alu_b};
      3'b100: alu_res = rs1_v ^ alu_b;
      3'b101: begin
        if (instr[30]) alu_res = $signed(rs1_v) >>> shamt;
        else           alu_res = rs1_v >> shamt;
      end
      3'b110: alu_res = rs1_v | alu_b;
      3'b111: alu_res = rs1_v & alu_b;
      default: alu_res = 32'h0000_0000;
    endcase
  end

  // Instruction decode: write-back value, control flow, store lanes and halt causes.
  always_comb begin
    illegal  = 1'b0;
    is_sys   = 1'b0;
    is_load  = 1'b0;
    wb_en    = 1'b0;
    wb_val   = 32'h0000_0000;
    jump     = 1'b0;
    next_pc  = pc_plus4;
    st_en    = 1'b0;
    st_be    = 4'b0000;
    st_data  = 32'h0000_0000;
    misalign = 1'b0;
    case (opcode)
      OP_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
      OP_AUIPC: begin wb_en = 1'b1; wb_val = pc_q + imm_u; end
      OP_JAL: begin
        wb_en = 1'b1; wb_val = pc_plus4; jump = 1'b1; next_pc = pc_q + imm_j;
      end
      OP_JALR: begin
        wb_en = 1'b1; wb_val = pc_plus4; jump = 1'b1;
        next_pc = (rs1_v + imm_i) & ~32'h0000_0001;
        if (funct3 != 3'b000) illegal = 1'b1;
        else                  illegal = 1'b0;
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  jump = (rs1_v == rs2_v);
          3'b001:  jump = (rs1_v != rs2_v);
          3'b100:  jump = ($signed(rs1_v) <  $signed(rs2_v));
          3'b101:  jump = ($signed(rs1_v) >= $signed(rs2_v));
          3'b110:  jump = (rs1_v <  rs2_v);
          3'b111:  jump = (rs1_v >= rs2_v);
          default: illegal = 1'b1;
        endcase
        if (jump) next_pc = pc_q + imm_b;
        else      next_pc = pc_plus4;
      end
      OP_LOAD: begin
        is_load = 1'b1;
        case (funct3)
          3'b000, 3'b100: misalign = 1'b0;
          3'b001, 3'b101: misalign = mem_addr[0];
          3'b010:         misalign = |mem_addr[1:0];
          default:        illegal  = 1'b1;
        endcase
      end
      OP_STORE: begin
        st_en = 1'b1;
        case (funct3)
          3'b000: begin
            st_be   = 4'b0001 << mem_addr[1:0];
            st_data = {4{rs2_v[7:0]}};
          end
          3'b001: begin
            st_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
            st_data  = {2{rs2_v[15:0]}};
            misalign = mem_addr[0];
          end
          3'b010: begin
            st_be    = 4'b1111;
            st_data  = rs2_v;
            misalign = |mem_addr[1:0];
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_IMM, OP_REG: begin wb_en = 1'b1; wb_val = alu_res; end
      OP_FENCE:  wb_en  = 1'b0;
      OP_SYSTEM: is_sys = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

  // Load lane extraction using the byte offset captured in EXEC.
  always_comb begin
    ld_shift = dmem_rdata >> {ld_off_q, 3'b000};
    case (ld_f3_q)
      3'b000:  load_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  load_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  load_val = ld_shift;
      3'b100:  load_val = {24'h00_0000, ld_shift[7:0]};
      3'b101:  load_val = {16'h0000, ld_shift[15:0]};
      default: load_val = 32'h0000_0000;
    endcase
  end

  // Sequencer next state; a halting instruction commits nothing, and reset masks the store.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halt_d   = halt_q;
    rf_we    = 1'b0;
    rf_wa    = rd;
    rf_wd    = wb_val;
    dmem_we  = 1'b0;
    ld_rd_d  = ld_rd_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    case (state_q)
      FETCH: state_d = EXEC;
      EXEC: begin
        if (halt_cond) begin
          state_d = HALT;
          halt_d  = 1'b1;
        end else if (is_load) begin
          state_d  = MEM;
          pc_d     = next_pc;
          ld_rd_d  = rd;
          ld_f3_d  = funct3;
          ld_off_d = mem_addr[1:0];
        end else begin
          state_d = FETCH;
          pc_d    = next_pc;
          rf_we   = wb_en;
          dmem_we = st_en & ~rst;
        end
      end
      MEM: begin
        state_d = FETCH;
        rf_we   = 1'b1;
        rf_wa   = ld_rd_q;
        rf_wd   = load_val;
      end
      HALT: begin
        state_d = HALT;
        halt_d  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Architectural state with synchronous reset; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      halt_q   <= 1'b0;
      ld_rd_q  <= 5'd0;
      ld_f3_q  <= 3'd0;
      ld_off_q <= 2'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halt_q   <= halt_d;
      ld_rd_q  <= ld_rd_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
      if (rf_we && (rf_wa != 5'd0)) rf_q[rf_wa] <= rf_wd;
    end
  end
endmodule

// File: tb/tb_kv32_top.sv
// Directed bench for kv32_top: programs are backdoor-loaded into i_imem and
// results compared against hand-computed register, memory and timing values.

module tb_kv32_top;
  logic clk;
  logic rst;
  logic halt;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  kv32_top dut (.clk(clk), .rst(rst), .halt(halt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    dut.i_imem.mem[addr >> 2] = w;
  endtask

  // Assert reset for two edges and wipe imem (all-zero words are illegal and halt).
  task automatic hold_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 1024; i++) dut.i_imem.mem[i] = 32'h0000_0000;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (halt !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, {31'd0, halt}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;

    // Reset state, then ADDI/ADDI/ECALL with exact halt timing.
    hold_reset();
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_pc", dut.pc_q, 32'h0);
    chk("rst_x31", dut.rf_q[31], 32'h0);
    put(0, enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13));
    put(4, enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, 7'h13));
    put(8, ECALL);
    release_rst();
    repeat (5) @(posedge clk);
    #1;
    chk("t1_halt_c5", {31'd0, halt}, 32'd0);
    @(posedge clk);
    #1;
    chk("t1_halt_c6", {31'd0, halt}, 32'd1);
    chk("t1_x1", dut.rf_q[1], 32'd5);
    chk("t1_x2", dut.rf_q[2], 32'hFFFF_FFFE);
    chk("t1_pc", dut.pc_q, 32'h8);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_halt_sticky", {31'd0, halt}, 32'd1);
    chk("t1_pc_sticky", dut.pc_q, 32'h8);

    // Loads and stores of every width, with sign/zero extension.
    hold_reset();
    dut.i_dmem.mem[2] = 32'hAABB_CCDD;
    dut.i_dmem.mem[3] = 32'h1122_3344;
    put(0,  {20'h12345, 5'd1, 7'h37});
    put(4,  enc_i(12'h678, 5'd1, 3'b000, 5'd1, 7'h13));
    put(8,  enc_s(12'd4, 5'd1, 5'd0, 3'b010));
    put(12, enc_i(12'd5, 5'd0, 3'b000, 5'd2, 7'h03));
    put(16, enc_i(12'd7, 5'd0, 3'b100, 5'd3, 7'h03));
    put(20, enc_s(12'd9, 5'd1, 5'd0, 3'b000));
    put(24, enc_s(12'd14, 5'd1, 5'd0, 3'b001));
    put(28, enc_i(12'd10, 5'd0, 3'b001, 5'd5, 7'h03));
    put(32, enc_i(12'd10, 5'd0, 3'b101, 5'd6, 7'h03));
    put(36, enc_i(12'd4, 5'd0, 3'b010, 5'd7, 7'h03));
    put(40, enc_i(12'd8, 5'd0, 3'b000, 5'd8, 7'h03));
    put(44, ECALL);
    release_rst();
    wait_halt("t2_halt");
    chk("t2_dmem1", dut.i_dmem.mem[1], 32'h1234_5678);
    chk("t2_lb", dut.rf_q[2], 32'h0000_0056);
    chk("t2_lbu", dut.rf_q[3], 32'h0000_0012);
    chk("t2_sb", dut.i_dmem.mem[2], 32'hAABB_78DD);
    chk("t2_sh", dut.i_dmem.mem[3], 32'h5678_3344);
    chk("t2_lh", dut.rf_q[5], 32'hFFFF_AABB);
    chk("t2_lhu", dut.rf_q[6], 32'h0000_AABB);
    chk("t2_lw", dut.rf_q[7], 32'h1234_5678);
    chk("t2_lb_neg", dut.rf_q[8], 32'hFFFF_FFDD);

    // Count-down loop: 7 two-cycle instructions, ECALL halts on the 16th edge.
    hold_reset();
    put(0,  enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'h13));
    put(4,  enc_i(12'hFFF, 5'd1, 3'b000, 5'd1, 7'h13));
    put(8,  enc_b(13'h1FFC, 5'd0, 5'd1, 3'b001));
    put(12, ECALL);
    release_rst();
    repeat (15) @(posedge clk);
    #1;
    chk("t3_halt_c15", {31'd0, halt}, 32'd0);
    @(posedge clk);
    #1;
    chk("t3_halt_c16", {31'd0, halt}, 32'd1);
    chk("t3_x1", dut.rf_q[1], 32'd0);
    chk("t3_pc", dut.pc_q, 32'd12);

    // JAL link/target, x0 immutability, JALR clears bit 0 of the target.
    hold_reset();
    put(0,  enc_j(21'd16, 5'd0));
    put(16, enc_j(21'd8, 5'd1));
    put(20, ECALL);
    put(24, enc_i(12'd1, 5'd0, 3'b000, 5'd0, 7'h13));
    put(28, enc_i(12'd1, 5'd1, 3'b000, 5'd2, 7'h67));
    release_rst();
    wait_halt("t4_halt");
    chk("t4_x1", dut.rf_q[1], 32'h14);
    chk("t4_x2", dut.rf_q[2], 32'h20);
    chk("t4_x0", dut.rf_q[0], 32'h0);
    chk("t4_pc", dut.pc_q, 32'h14);

    // Misaligned LW halts without write-back; reset restarts execution.
    hold_reset();
    put(0, enc_i(12'd9, 5'd0, 3'b000, 5'd1, 7'h13));
    put(4, enc_i(12'd2, 5'd0, 3'b010, 5'd1, 7'h03));
    release_rst();
    repeat (4) @(posedge clk);
    #1;
    chk("t5_halt", {31'd0, halt}, 32'd1);
    chk("t5_x1", dut.rf_q[1], 32'd9);
    chk("t5_pc", dut.pc_q, 32'd4);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rst_halt", {31'd0, halt}, 32'd0);
    chk("t5_rst_pc", dut.pc_q, 32'd0);
    chk("t5_rst_x1", dut.rf_q[1], 32'd0);
    release_rst();
    wait_halt("t5_rehalt");
    chk("t5_re_x1", dut.rf_q[1], 32'd9);

    // Reset during the store's EXEC cycle must suppress the write.
    hold_reset();
    dut.i_dmem.mem[0] = 32'h0000_0000;
    put(0, enc_i(12'h055, 5'd0, 3'b000, 5'd1, 7'h13));
    put(4, enc_s(12'd0, 5'd1, 5'd0, 3'b010));
    put(8, ECALL);
    release_rst();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_abort_nowrite", dut.i_dmem.mem[0], 32'h0);
    release_rst();
    wait_halt("t6_halt");
    chk("t6_store", dut.i_dmem.mem[0], 32'h55);

    // Shifts, signed/unsigned compares, SUB, shift amount masked to 5 bits.
    hold_reset();
    put(0,  {20'h80000, 5'd1, 7'h37});
    put(4,  enc_i(12'h404, 5'd1, 3'b101, 5'd2, 7'h13));
    put(8,  enc_r(7'h00, 5'd1, 5'd0, 3'b011, 5'd3));
    put(12, enc_r(7'h00, 5'd1, 5'd0, 3'b010, 5'd4));
    put(16, enc_i(12'h004, 5'd1, 3'b101, 5'd5, 7'h13));
    put(20, enc_i(12'd33, 5'd0, 3'b000, 5'd8, 7'h13));
    put(24, enc_r(7'h00, 5'd8, 5'd3, 3'b001, 5'd7));
    put(28, enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd6));
    put(32, ECALL);
    release_rst();
    wait_halt("t7_halt");
    chk("t7_srai", dut.rf_q[2], 32'hF800_0000);
    chk("t7_sltu", dut.rf_q[3], 32'd1);
    chk("t7_slt", dut.rf_q[4], 32'd0);
    chk("t7_srli", dut.rf_q[5], 32'h0800_0000);
    chk("t7_sll", dut.rf_q[7], 32'd2);
    chk("t7_sub", dut.rf_q[6], 32'h8000_0001);

    // Taken branch to a target with bit 1 set halts and leaves PC unchanged.
    hold_reset();
    put(0, enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'h13));
    put(4, enc_b(13'd6, 5'd0, 5'd0, 3'b000));
    release_rst();
    repeat (4) @(posedge clk);
    #1;
    chk("t8_halt", {31'd0, halt}, 32'd1);
    chk("t8_pc", dut.pc_q, 32'd4);
    chk("t8_x1", dut.rf_q[1], 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/kv32_top.md
KV32_TOP -- requirements
Module: kv32_top

Interface
REQ-001 Parameter IMEM_DEPTH, default 1024, instruction memory size in 32-bit words (power of two).
REQ-002 Parameter DMEM_DEPTH, default 1024, data memory size in 32-bit words (power of two).
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 halt  output  1  registered; high once the core has stopped executing.
REQ-007 Instruction memory SHALL be a submodule instance named i_imem holding array mem[0:IMEM_DEPTH-1] of 32-bit words, writable by a bench backdoor before the first fetch.
REQ-008 Byte address A SHALL map to mem[A/4] bits (A%4)*8+7 down to (A%4)*8, i.e. little-endian.
REQ-009 Data memory SHALL be a separate instance named i_dmem with the same array name, layout and byte mapping, sized DMEM_DEPTH.

Function
REQ-010 The core SHALL execute RV32I: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP instructions.
REQ-011 The core SHALL use FSM states FETCH, EXEC, MEM, HALT; FETCH presents PC to i_imem, which has 1-cycle synchronous read latency.
REQ-012 FETCH SHALL always go to EXEC.
REQ-013 EXEC SHALL go to MEM for loads, to HALT on a halt condition, otherwise back to FETCH.
REQ-014 MEM SHALL always go to FETCH.
REQ-015 HALT SHALL be left only by rst.
REQ-016 Instruction latency: 2 cycles for non-load instructions, 3 cycles for loads.
REQ-017 Stores SHALL write i_dmem in EXEC with per-byte enables; SB/SH SHALL modify only the addressed bytes.
REQ-018 Loads SHALL read i_dmem synchronously and write back in MEM; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-019 Register file: 32x32 bits; x0 SHALL read as 0 and ignore writes.
REQ-020 Register write-back SHALL occur in EXEC, or in MEM for loads.
REQ-021 Arithmetic SHALL be modulo 2^32; shifts SHALL use the low 5 bits of the shift amount; SRA/SRAI SHALL be arithmetic.
REQ-022 SLT SHALL compare signed; SLTU SHALL compare unsigned.
REQ-023 JAL/JALR SHALL write PC+4 to rd; JALR target SHALL be (rs1+imm) with bit 0 cleared.
REQ-024 The imem word index SHALL be PC[log2(IMEM_DEPTH)+1:2]; the dmem index SHALL be addr[log2(DMEM_DEPTH)+1:2] (wrap-around, no fault).
REQ-025 FENCE SHALL execute as a NOP.
REQ-026 Halt conditions, evaluated in EXEC: ECALL, EBREAK, unsupported opcode, taken branch/jump target with bit 1 set, misaligned LH/LHU/SH (addr[0]=1), misaligned LW/SW (addr[1:0]!=0).
REQ-027 A halting instruction SHALL NOT write registers or memory and SHALL NOT advance PC.
REQ-028 halt SHALL assert on the clock edge entering HALT and remain 1.

Reset
REQ-029 While rst=1 at a clock edge: state<=FETCH, PC<=RESET_PC, halt<=0, all registers x1..x31<=0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 rst asserted mid-instruction (any state) SHALL abort it with no memory write on that edge.
REQ-032 The first fetch SHALL occur in the cycle after rst deasserts.

Verification
REQ-033 Load ADDI x1,x0,5; ADDI x2,x1,-7; ECALL at address 0 -> x1=5, x2=0xFFFFFFFE, halt=1 six cycles after reset release, PC=8.
REQ-034 LUI x1,0x12345; ADDI x1,x1,0x678; SW x1,4(x0); LB x2,5(x0); LBU x3,7(x0); ECALL -> dmem word1=0x12345678, x2=0x56, x3=0x12.
REQ-035 Loop ADDI x1,x0,3; loop: ADDI x1,x1,-1; BNE x1,x0,loop; ECALL -> x1=0, BNE taken twice, halt after 1+3+3 instructions.
REQ-036 JAL x1,+8 at address 0x10 -> x1=0x14, next fetch from 0x18; ADDI x0,x0,1 -> x0 stays 0.
REQ-037 LW x1,2(x0) -> halt=1, x1 unchanged; then pulse rst -> halt=0, PC=RESET_PC, execution restarts.
REQ-038 SRAI x2,x1,4 with x1=0x80000000 -> x2=0xF8000000; SLTU x3,x0,x1 -> x3=1; SLT x4,x0,x1 -> x4=0.
